load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ALLOW_UNSELECTED, default 0, meaning when 0 an access with mem_selected=0 faults (cause 2'b10), when 1 it completes with read data 0 and the write is dropped.
REQ-002 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  CPU request present.
REQ-005 SHALL have port: req_ready  out  1  unit accepts a request this cycle.
REQ-006 SHALL have port: req_we  in  1  0=load, 1=store.
REQ-007 SHALL have port: req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 SHALL have port: req_unsigned  in  1  zero-extend loads (lbu/lhu).
REQ-009 SHALL have port: req_addr  in  32  byte address.
REQ-010 SHALL have port: req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: rsp_rdata  out  32  extended load result.
REQ-013 SHALL have port: rsp_fault  out  1  request faulted.
REQ-014 SHALL have port: rsp_cause  out  2  01=misaligned/illegal size, 10=access fault, 00=none.
REQ-015 SHALL have port: mem_rw  out  1  to word memory, 0=read, 1=write.
REQ-016 SHALL have port: mem_address  out  32  word-aligned memory address.
REQ-017 SHALL have port: mem_write_data  out  32  full word to write.
REQ-018 SHALL have port: mem_read_data  in  32  asynchronous word read data.
REQ-019 SHALL have port: mem_selected  in  1  memory decodes mem_address.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-021 IDLE: on req_valid SHALL latch we, size, unsigned, addr, wdata; misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11 -> RESP with fault, cause 01, no memory access; otherwise -> READ.
REQ-022 READ: SHALL drive mem_rw=0, mem_address={addr[31:2],2'b00} and sample mem_read_data and mem_selected at the cycle-ending edge.
REQ-023 READ exit: mem_selected=0 and ALLOW_UNSELECTED=0 -> RESP, cause 10; load -> RESP with extracted data; store -> WRITE with merged word.
REQ-024 Load extraction SHALL select byte lane addr[1:0] (byte) or half addr[1] (half), sign-extend unless req_unsigned; word loads ignore req_unsigned.
REQ-025 Store merge SHALL replace byte lane addr[1:0] with wdata[7:0] (byte), half addr[1] with wdata[15:0] (half), entire word (word), other bytes from sampled read word.
REQ-026 WRITE: SHALL drive mem_rw=1, same aligned mem_address, mem_write_data=merged word for exactly one cycle, then -> RESP.
REQ-027 RESP: rsp_valid=1 for exactly one cycle, then -> IDLE; rsp_rdata=0 for stores and faults; rsp_fault/rsp_cause valid only while rsp_valid=1, else 0.
REQ-028 Outside READ/WRITE, mem_rw=0, mem_address=0, mem_write_data=0.
REQ-029 Latency: load request accepted cycle N -> rsp_valid cycle N+2; store -> N+3; misaligned -> N+1.
REQ-030 Requests presented while req_ready=0 SHALL be ignored; a new request accepted in IDLE the cycle after RESP.
REQ-031 Response path SHALL have no backpressure; upstream must consume rsp_valid when pulsed.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_fault=0, rsp_cause=0, rsp_rdata=0, mem_rw=0, mem_address=0, mem_write_data=0, latched request cleared.
REQ-033 Reset asserted during READ or WRITE SHALL abort the access with no memory write completing and no response pulse; req_ready=1 after release.

Verification
REQ-034 Word 0x80000010 holds 0x11223344; lb addr 0x80000013 -> rsp_rdata 0x00000011 at N+2; lb addr 0x80000010 with word 0xAABBCC80 -> 0xFFFFFF80; lbu -> 0x00000080.
REQ-035 Word 0x80000020=0x11223344; sh 0x80000022 wdata 0xBEEF -> WRITE cycle mem_write_data 0xBEEF3344, rsp_valid at N+3, rsp_fault=0.
REQ-036 lw 0x80000002 -> rsp_valid at N+1, rsp_fault=1, rsp_cause 01, mem_rw never 1, no READ cycle.
REQ-037 sw 0x00001000 with mem_selected=0, ALLOW_UNSELECTED=0 -> rsp_fault=1, cause 10, no WRITE cycle.
REQ-038 sb 0x80000031 wdata 0x5A, rst_n low during WRITE -> mem_rw falls immediately, memory word unchanged, no rsp_valid.
REQ-039 Back-to-back: lw then sw held on req_valid -> second accepted only after first rsp_valid, req_ready=0 in between.

Source files
------------

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-wide memory.
// Sub-word stores are read-modify-write; loads extract and extend one lane.
module load_store_unit #(
  parameter logic ALLOW_UNSELECTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [1:0]  rsp_cause,
  output logic        mem_rw,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_selected
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d, fault_q, fault_d;
  logic [1:0]  size_q, size_d, cause_q, cause_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;

  logic        misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, store_merged;

  always_comb begin
    unique case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Lane extraction and merge both work on the word sampled during READ.
  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   lane_b = mem_read_data[7:0];
      2'b01:   lane_b = mem_read_data[15:8];
      2'b10:   lane_b = mem_read_data[23:16];
      default: lane_b = mem_read_data[31:24];
    endcase
    lane_h = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_ext = mem_read_data;
    endcase
    store_merged = mem_read_data;
    unique case (size_q)
      2'b00: begin
        unique case (addr_q[1:0])
          2'b00:   store_merged[7:0]   = wdata_q[7:0];
          2'b01:   store_merged[15:8]  = wdata_q[7:0];
          2'b10:   store_merged[23:16] = wdata_q[7:0];
          default: store_merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) store_merged[31:16] = wdata_q[15:0];
        else           store_merged[15:0]  = wdata_q[15:0];
      end
      default: store_merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    fault_d = fault_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          data_d  = '0;
          fault_d = misaligned;
          cause_d = misaligned ? 2'b01 : 2'b00;
          state_d = misaligned ? RESP : READ;
        end
      end
      READ: begin
        if (!mem_selected && !ALLOW_UNSELECTED) begin
          fault_d = 1'b1;
          cause_d = 2'b10;
          data_d  = '0;
          state_d = RESP;
        end else if (!we_q) begin
          data_d  = mem_selected ? load_ext : '0;
          state_d = RESP;
        end else if (!mem_selected) begin
          // tolerated unselected store: nothing is written
          data_d  = '0;
          state_d = RESP;
        end else begin
          data_d  = store_merged;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  always_comb begin
    req_ready      = (state_q == IDLE);
    rsp_valid      = (state_q == RESP);
    rsp_fault      = 1'b0;
    rsp_cause      = 2'b00;
    rsp_rdata      = '0;
    mem_rw         = (state_q == WRITE);
    mem_address    = '0;
    mem_write_data = '0;
    if (state_q == RESP) begin
      rsp_fault = fault_q;
      rsp_cause = cause_q;
      rsp_rdata = (we_q || fault_q) ? 32'h0 : data_q;
    end
    if (state_q == READ || state_q == WRITE) mem_address = {addr_q[31:2], 2'b00};
    if (state_q == WRITE) mem_write_data = data_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-array model
// of a 64-word memory decoded at 0x8xxxxxxx.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_fault, mem_rw, mem_selected;
  logic [1:0]  rsp_cause;
  logic [31:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.ALLOW_UNSELECTED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
    .mem_rw(mem_rw), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_selected(mem_selected)
  );

  always #5 clk = ~clk;

  assign mem_selected  = (mem_address[31:28] == 4'h8);
  assign mem_read_data = mem_selected ? mem[mem_address[7:2]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_dat;
    else if (mem_rw && mem_selected) mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_dat = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One request end to end; expectations come from a byte-lane model of memory.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] word, exp_rd, exp_merge;
    logic [7:0]  b [4];
    logic        exp_fault;
    logic [1:0]  exp_cause;
    int nb, off, exp_lat, exp_reads, exp_writes, lat, reads, writes;
    bit illegal, sel;
    word = mem[a[7:2]];
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    off = int'(a[1:0]);
    nb = (sz == 2'b11) ? 4 : (1 << sz);
    illegal = (sz == 2'b11) || ((off % nb) != 0);
    sel = (a[31:28] == 4'h8);
    exp_rd = '0; exp_merge = word; exp_fault = 1'b0; exp_cause = 2'b00;
    exp_reads = 1; exp_writes = 0;
    if (illegal) begin
      exp_lat = 1; exp_fault = 1'b1; exp_cause = 2'b01; exp_reads = 0;
    end else if (!sel) begin
      exp_lat = 2; exp_fault = 1'b1; exp_cause = 2'b10;
    end else if (!we) begin
      exp_lat = 2;
      for (int i = 0; i < nb; i++) exp_rd |= 32'(b[off+i]) << (8*i);
      if (!uns && nb < 4 && exp_rd[8*nb-1]) exp_rd |= 32'hFFFF_FFFF << (8*nb);
    end else begin
      exp_lat = 3; exp_writes = 1;
      for (int i = 0; i < nb; i++) b[off+i] = wd[8*i +: 8];
      exp_merge = {b[3], b[2], b[1], b[0]};
    end

    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; reads = 0; writes = 0;
    while (!rsp_valid && lat < 8) begin
      if (mem_rw) begin
        writes++;
        check({tag, "_wdata"}, mem_write_data, exp_merge);
      end else if (mem_address !== 32'h0) reads++;
      if (mem_rw || mem_address !== 32'h0)
        check({tag, "_maddr"}, mem_address, {a[31:2], 2'b00});
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_fault"}, 32'(rsp_fault), 32'(exp_fault));
    check({tag, "_cause"}, 32'(rsp_cause), 32'(exp_cause));
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_reads"}, 32'(reads), 32'(exp_reads));
    check({tag, "_writes"}, 32'(writes), 32'(exp_writes));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_memrw"}, {mem_rw, mem_address[30:0]}, 32'h0);
    if (sel) check({tag, "_memword"}, mem[a[7:2]], exp_merge);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'h0, rsp_valid | rsp_fault}, 32'h0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check("reset_rsp", {rsp_valid, rsp_fault, rsp_cause, rsp_rdata[27:0]}, 32'h0);
    check("reset_mem", {mem_rw, mem_address[30:0]}, 32'h0);
    check("reset_wdata", mem_write_data, 32'h0);
    check("reset_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);

    preload(6'd4, 32'h11223344);
    run_req(1'b0, 2'b00, 1'b0, 32'h8000_0013, 32'h0, "lb_hi");
    preload(6'd4, 32'hAABBCC80);
    run_req(1'b0, 2'b00, 1'b0, 32'h8000_0010, 32'h0, "lb_neg");
    run_req(1'b0, 2'b00, 1'b1, 32'h8000_0010, 32'h0, "lbu");
    preload(6'd8, 32'h11223344);
    run_req(1'b1, 2'b01, 1'b0, 32'h8000_0022, 32'h0000BEEF, "sh_hi");
    check("sh_word", mem[8], 32'hBEEF3344);
    run_req(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, "lw_misal");
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h12345678, "sw_unsel");
    run_req(1'b0, 2'b11, 1'b0, 32'h8000_0004, 32'h0, "size11");

    // reset in the middle of a write must leave memory untouched
    preload(6'd12, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h8000_0031; req_wdata = 32'h0000005A;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstw_inwrite", 32'(mem_rw), 32'd1);
    check("rstw_wdata", mem_write_data, 32'h11225A44);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_memrw", {mem_rw, mem_address[30:0]}, 32'h0);
    check("rstw_wd0", mem_write_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstw_norsp", 32'(rsp_valid), 32'd0);
    end
    check("rstw_memkeep", mem[12], 32'h11223344);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_ready", 32'(req_ready), 32'd1);

    // back-to-back: second request held on req_valid while busy
    preload(6'd16, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b_ready0", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h8000_0040;
    @(negedge clk);
    check("b2b_busy_rd", 32'(req_ready), 32'd0);
    req_we = 1'b1; req_addr = 32'h8000_0044; req_wdata = 32'h0BADC0DE;
    @(negedge clk);
    check("b2b_rsp1", 32'(rsp_valid), 32'd1);
    check("b2b_rdata1", rsp_rdata, 32'hCAFEF00D);
    check("b2b_busy_rsp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("b2b_accept2", {30'h0, req_ready, rsp_valid}, 32'h2);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_read2", 32'(mem_rw), 32'd0);
    @(negedge clk);
    check("b2b_write2", {31'h0, mem_rw}, 32'h1);
    check("b2b_wdata2", mem_write_data, 32'h0BADC0DE);
    @(negedge clk);
    check("b2b_rsp2", {30'h0, rsp_valid, rsp_fault}, 32'h2);
    check("b2b_mem2", mem[17], 32'h0BADC0DE);

    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a   = ($urandom_range(0, 7) == 0) ? {24'h000010, 8'($urandom)}
                                        : {24'h800000, 8'($urandom)};
      run_req(we, sz, uns, a, $urandom, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
